dodge_obstacle_ctrl: RTL

Falling-obstacle controller for the dodge game. It sits directly downstream of the obstacle-rate divider and consumes its divided square wave. Each rising edge of that wave advances one obstacle one row down an 8×8 field. The block spawns each obstacle in a pseudo-random column, detects a collision with the player on the bottom row, and counts successful dodges.

---
 rtl/dodge_pkg.sv | 26 ++
 rtl/edge_sync.sv | 31 +++
 rtl/dodge_obstacle_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/dodge_pkg.sv
// Shared types and constants for the dodge-game obstacle controller.
// Holds the FSM state encoding, LFSR geometry and the dodge counter limit.
package dodge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPAWN = 2'd1,
    FALL  = 2'd2,
    OVER  = 2'd3
  } state_e;

  localparam int                LFSR_W       = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 8'hB8;
  localparam logic [7:0]        DODGE_MAX    = 8'hFF;
  localparam int                ROWS_DEFAULT = 8;

  // Fibonacci step for x^8+x^6+x^5+x^4+1: the feedback bit is the parity of the tapped bits.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_seed_fix(input logic [LFSR_W-1:0] s);
    return (s == {LFSR_W{1'b0}}) ? {{(LFSR_W-1){1'b0}}, 1'b1} : s;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus a delay flop; rise is high for one CLK cycle
// per rising edge of the asynchronous input d.
module edge_sync
  import dodge_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;

  // Synchronizer chain; r_sync3 holds the previous synchronized level.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= d;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign rise = r_sync2 & ~r_sync3;

endmodule

// File: rtl/dodge_obstacle_ctrl.sv
// Falling-obstacle controller: spawns an obstacle in an LFSR-chosen column,
// moves it down one row per fall_clk rise, detects collisions and counts dodges.
module dodge_obstacle_ctrl
  import dodge_pkg::*;
#(
  parameter int         ROWS      = ROWS_DEFAULT,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       fall_clk,
  input  logic       start,
  input  logic [2:0] player_col,
  output logic [2:0] obj_row,
  output logic [2:0] obj_col,
  output logic       obj_valid,
  output logic       hit,
  output logic       game_over,
  output logic [7:0] dodge_cnt
);

  localparam logic [2:0]        LAST_ROW   = 3'(ROWS - 1);
  localparam logic [LFSR_W-1:0] SEED_FIXED = lfsr_seed_fix(LFSR_SEED);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [LFSR_W-1:0] r_lfsr;
  logic [2:0]        r_row;
  logic [2:0]        w_row_nxt;
  logic [2:0]        r_col;
  logic [2:0]        w_col_nxt;
  logic              r_valid;
  logic              w_valid_nxt;
  logic              r_hit;
  logic              w_hit_nxt;
  logic              r_over;
  logic              w_over_nxt;
  logic [7:0]        r_cnt;
  logic [7:0]        w_cnt_nxt;
  logic              w_step;
  logic              w_collide;

  edge_sync u_fall_sync (
    .CLK  (CLK),
    .RST  (RST),
    .d    (fall_clk),
    .rise (w_step)
  );

  // Free-running LFSR; it advances in every state so spawn columns vary with play timing.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_lfsr <= SEED_FIXED;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign w_collide = (r_row == LAST_ROW) && (r_col == player_col);

  // Next-state and next-output logic; collision is checked ahead of step.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_valid_nxt = r_valid;
    w_hit_nxt   = 1'b0;
    w_over_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        w_valid_nxt = 1'b0;
        if (start) begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = SPAWN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SPAWN: begin
        w_col_nxt   = r_lfsr[2:0];
        w_row_nxt   = 3'd0;
        w_valid_nxt = 1'b1;
        w_state_nxt = FALL;
      end
      FALL: begin
        if (w_collide) begin
          w_hit_nxt   = 1'b1;
          w_over_nxt  = 1'b1;
          w_state_nxt = OVER;
        end else if (w_step) begin
          if (r_row < LAST_ROW) begin
            w_row_nxt = r_row + 3'd1;
          end else begin
            w_cnt_nxt   = (r_cnt == DODGE_MAX) ? r_cnt : r_cnt + 8'd1;
            w_state_nxt = SPAWN;
          end
        end else begin
          w_state_nxt = FALL;
        end
      end
      OVER: begin
        if (start) begin
          w_over_nxt  = 1'b1;
          w_state_nxt = OVER;
        end else begin
          w_valid_nxt = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; every output is driven straight from here.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_row   <= 3'd0;
      r_col   <= 3'd0;
      r_valid <= 1'b0;
      r_hit   <= 1'b0;
      r_over  <= 1'b0;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_valid <= w_valid_nxt;
      r_hit   <= w_hit_nxt;
      r_over  <= w_over_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign obj_row   = r_row;
  assign obj_col   = r_col;
  assign obj_valid = r_valid;
  assign hit       = r_hit;
  assign game_over = r_over;
  assign dodge_cnt = r_cnt;

endmodule
